// File: rtl/qunion_merge_if.sv
// Valid/ready stream link between the merge and its neighbours.
// An item transfers on a rising clk edge where valid && ready; the producer holds data stable while valid && !ready.
interface qunion_merge_if #(
    parameter int W = 17
);
    logic [W-1:0] data;
    logic         valid;
    logic         ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/qunion_merge.sv
// Merges two queue streams into one union-tagged stream {eot, ctrl, data}, arbitrating per
// outermost transaction so items from the two inputs are never interleaved inside a transaction.
module qunion_merge #(
    parameter int W_DIN = 16,
    parameter int LVL   = 1
) (
    input  logic                clk,
    input  logic                rst,
    qunion_merge_if.slave       din0,
    qunion_merge_if.slave       din1,
    qunion_merge_if.master      dout,
    output logic [1:0]          o_dbg_state
);
    localparam int DW = LVL + W_DIN;
    localparam int OW = LVL + 1 + W_DIN;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOCK0 = 2'd1,
        S_LOCK1 = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_last;
    logic            r_valid;
    logic [OW-1:0]   r_data;

    logic            w_can_load;
    logic            w_gnt_vld;
    logic            w_gnt;
    logic            w_src_valid;
    logic            w_accept;
    logic [DW-1:0]   w_item;

    assign w_can_load = !r_valid || dout.ready;

    // Grant is combinational in IDLE so the first item of a transaction costs no bubble.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = 1'b0;
        case (r_state)
            S_LOCK0: begin
                w_gnt_vld = 1'b1;
                w_gnt     = 1'b0;
            end
            S_LOCK1: begin
                w_gnt_vld = 1'b1;
                w_gnt     = 1'b1;
            end
            default: begin
                if (din0.valid && din1.valid) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = !r_last;
                end else if (din0.valid) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = 1'b0;
                end else if (din1.valid) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = 1'b1;
                end
            end
        endcase
    end

    assign w_src_valid = w_gnt ? din1.valid : din0.valid;
    assign w_item      = w_gnt ? din1.data  : din0.data;
    assign w_accept    = w_gnt_vld && w_src_valid && w_can_load && !rst;

    assign din0.ready  = w_gnt_vld && !w_gnt && w_can_load && !rst;
    assign din1.ready  = w_gnt_vld &&  w_gnt && w_can_load && !rst;

    // Only the outermost eot bit closes a transaction; inner eot bits keep the lock.
    always_comb begin
        w_state_nxt = r_state;
        if (w_accept) begin
            if (w_item[DW-1]) begin
                w_state_nxt = S_IDLE;
            end else begin
                w_state_nxt = w_gnt ? S_LOCK1 : S_LOCK0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_data  <= {w_item[DW-1:W_DIN], w_gnt, w_item[W_DIN-1:0]};
                r_valid <= 1'b1;
                r_last  <= w_gnt;
            end else if (dout.ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign dout.valid  = r_valid;
    assign dout.data   = r_data;
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_qunion_merge.sv
// Bench for qunion_merge: instance a (LVL=1) and instance b (LVL=2), queue-fed drivers,
// scoreboard monitors per output, directed tests with hand-computed expected items.
module tb_qunion_merge;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    qunion_merge_if #(.W(17)) a_din0 ();
    qunion_merge_if #(.W(17)) a_din1 ();
    qunion_merge_if #(.W(18)) a_dout ();
    qunion_merge_if #(.W(18)) b_din0 ();
    qunion_merge_if #(.W(18)) b_din1 ();
    qunion_merge_if #(.W(19)) b_dout ();
    logic [1:0] a_state;
    logic [1:0] b_state;

    qunion_merge #(.W_DIN(16), .LVL(1)) u_a (
        .clk(clk), .rst(rst), .din0(a_din0), .din1(a_din1), .dout(a_dout), .o_dbg_state(a_state)
    );
    qunion_merge #(.W_DIN(16), .LVL(2)) u_b (
        .clk(clk), .rst(rst), .din0(b_din0), .din1(b_din1), .dout(b_dout), .o_dbg_state(b_state)
    );

    typedef struct {
        bit          gap;
        logic [17:0] d;
    } src_t;

    src_t        sa0_q[$];
    src_t        sa1_q[$];
    src_t        sb0_q[$];
    src_t        sb1_q[$];
    logic [17:0] exp_a_q[$];
    logic [18:0] exp_b_q[$];
    int          out_cyc[0:63];
    int          n_out = 0;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic src_t ia(input logic eot, input logic [15:0] d);
        ia.gap = 1'b0;
        ia.d   = {1'b0, eot, d};
    endfunction
    function automatic src_t ib(input logic [1:0] eot, input logic [15:0] d);
        ib.gap = 1'b0;
        ib.d   = {eot, d};
    endfunction
    function automatic src_t igap();
        igap.gap = 1'b1;
        igap.d   = '0;
    endfunction
    function automatic logic [17:0] ea(input logic eot, input logic ctrl, input logic [15:0] d);
        return {eot, ctrl, d};
    endfunction
    function automatic logic [18:0] eb(input logic [1:0] eot, input logic ctrl, input logic [15:0] d);
        return {eot, ctrl, d};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // ---------------- drivers ----------------
    initial begin
        bit hs;
        a_din0.valid = 1'b0;
        a_din0.data  = '0;
        forever begin
            @(negedge clk);
            hs = a_din0.valid && a_din0.ready;
            @(posedge clk);
            #1;
            if (hs) void'(sa0_q.pop_front());
            if (sa0_q.size() > 0 && sa0_q[0].gap) begin
                a_din0.valid = 1'b0;
                void'(sa0_q.pop_front());
            end else if (sa0_q.size() > 0) begin
                a_din0.valid = 1'b1;
                a_din0.data  = sa0_q[0].d[16:0];
            end else begin
                a_din0.valid = 1'b0;
            end
        end
    end

    initial begin
        bit hs;
        a_din1.valid = 1'b0;
        a_din1.data  = '0;
        forever begin
            @(negedge clk);
            hs = a_din1.valid && a_din1.ready;
            @(posedge clk);
            #1;
            if (hs) void'(sa1_q.pop_front());
            if (sa1_q.size() > 0) begin
                a_din1.valid = 1'b1;
                a_din1.data  = sa1_q[0].d[16:0];
            end else begin
                a_din1.valid = 1'b0;
            end
        end
    end

    initial begin
        bit hs;
        b_din0.valid = 1'b0;
        b_din0.data  = '0;
        forever begin
            @(negedge clk);
            hs = b_din0.valid && b_din0.ready;
            @(posedge clk);
            #1;
            if (hs) void'(sb0_q.pop_front());
            if (sb0_q.size() > 0) begin
                b_din0.valid = 1'b1;
                b_din0.data  = sb0_q[0].d;
            end else begin
                b_din0.valid = 1'b0;
            end
        end
    end

    initial begin
        bit hs;
        b_din1.valid = 1'b0;
        b_din1.data  = '0;
        forever begin
            @(negedge clk);
            hs = b_din1.valid && b_din1.ready;
            @(posedge clk);
            #1;
            if (hs) void'(sb1_q.pop_front());
            if (sb1_q.size() > 0) begin
                b_din1.valid = 1'b1;
                b_din1.data  = sb1_q[0].d;
            end else begin
                b_din1.valid = 1'b0;
            end
        end
    end

    // ---------------- scoreboard monitors ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (a_dout.valid === 1'b1 && a_dout.ready === 1'b1) begin
                if (exp_a_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL a_out_unexpected: got %h, expected no item", a_dout.data);
                end else begin
                    chk("a_out", a_dout.data, exp_a_q.pop_front());
                end
                if (n_out < 64) out_cyc[n_out] = cyc;
                n_out++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (b_dout.valid === 1'b1 && b_dout.ready === 1'b1) begin
                if (exp_b_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL b_out_unexpected: got %h, expected no item", b_dout.data);
                end else begin
                    chk("b_out", b_dout.data, exp_b_q.pop_front());
                end
            end
        end
    end

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            step();
            if (sa0_q.size() == 0 && sa1_q.size() == 0 && sb0_q.size() == 0 && sb1_q.size() == 0 &&
                exp_a_q.size() == 0 && exp_b_q.size() == 0 &&
                a_dout.valid !== 1'b1 && b_dout.valid !== 1'b1)
                done = 1'b1;
        end
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL %s_drain: got %0d/%0d items still expected, required 0 within 200 cycles",
                     name, exp_a_q.size(), exp_b_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    // ---------------- directed tests ----------------
    initial begin
        int c0;
        int n0;
        a_dout.ready = 1'b1;
        b_dout.ready = 1'b1;

        // Reset state, with test-1 items already presented on din0.
        sa0_q.push_back(ia(1'b0, 16'h0011));
        sa0_q.push_back(ia(1'b1, 16'h0022));
        exp_a_q.push_back(ea(1'b0, 1'b0, 16'h0011));
        exp_a_q.push_back(ea(1'b1, 1'b0, 16'h0022));
        rst = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("rst_dout_valid", a_dout.valid, 0);
        chk("rst_dout_data", a_dout.data, 0);
        chk("rst_din0_ready", a_din0.ready, 0);
        chk("rst_din1_ready", a_din1.ready, 0);
        chk("rst_state", a_state, 0);
        chk("rst_b_dout_valid", b_dout.valid, 0);
        step();
        rst = 1'b0;

        // Test 1: din0 only, no bubble, one-cycle latency, din1 never ready.
        @(negedge clk);
        c0 = cyc;
        chk("t1_din0_ready", a_din0.ready, 1);
        chk("t1_din1_ready", a_din1.ready, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t1_din1_ready", a_din1.ready, 0);
        end
        wait_drain("t1");
        chk("t1_count", n_out, 2);
        chk("t1_latency", out_cyc[0] - c0, 1);
        chk("t1_back2back", out_cyc[1] - out_cyc[0], 1);

        // Test 2: both valid, 2-item transactions, round robin starting at din0.
        rst = 1'b1;
        n0 = n_out;
        sa0_q.push_back(ia(1'b0, 16'h0A01));
        sa0_q.push_back(ia(1'b1, 16'h0A02));
        sa0_q.push_back(ia(1'b0, 16'h0A03));
        sa0_q.push_back(ia(1'b1, 16'h0A04));
        sa1_q.push_back(ia(1'b0, 16'h0B01));
        sa1_q.push_back(ia(1'b1, 16'h0B02));
        exp_a_q.push_back(ea(1'b0, 1'b0, 16'h0A01));
        exp_a_q.push_back(ea(1'b1, 1'b0, 16'h0A02));
        exp_a_q.push_back(ea(1'b0, 1'b1, 16'h0B01));
        exp_a_q.push_back(ea(1'b1, 1'b1, 16'h0B02));
        exp_a_q.push_back(ea(1'b0, 1'b0, 16'h0A03));
        exp_a_q.push_back(ea(1'b1, 1'b0, 16'h0A04));
        repeat (3) step();
        rst = 1'b0;
        wait_drain("t2");
        chk("t2_count", n_out - n0, 6);
        chk("t2_no_idle", out_cyc[n0 + 5] - out_cyc[n0], 5);

        // Test 3: din0 locked with a 3-cycle valid gap while din1 waits.
        n0 = n_out;
        sa0_q.push_back(ia(1'b0, 16'h0C01));
        sa0_q.push_back(igap());
        sa0_q.push_back(igap());
        sa0_q.push_back(igap());
        sa0_q.push_back(ia(1'b0, 16'h0C02));
        sa0_q.push_back(ia(1'b1, 16'h0C03));
        exp_a_q.push_back(ea(1'b0, 1'b0, 16'h0C01));
        exp_a_q.push_back(ea(1'b0, 1'b0, 16'h0C02));
        exp_a_q.push_back(ea(1'b1, 1'b0, 16'h0C03));
        exp_a_q.push_back(ea(1'b1, 1'b1, 16'h0D01));
        step();
        step();
        sa1_q.push_back(ia(1'b1, 16'h0D01));
        step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t3_din1_blocked", a_din1.ready, 0);
            chk("t3_state_lock0", a_state, 1);
            if (i < 3) chk("t3_dout_drained", a_dout.valid, 0);
        end
        wait_drain("t3");
        chk("t3_count", n_out - n0, 4);

        // Test 4: output backpressure for 4 cycles.
        n0 = n_out;
        a_dout.ready = 1'b0;
        sa0_q.push_back(ia(1'b0, 16'h0E01));
        sa0_q.push_back(ia(1'b0, 16'h0E02));
        sa0_q.push_back(ia(1'b1, 16'h0E03));
        exp_a_q.push_back(ea(1'b0, 1'b0, 16'h0E01));
        exp_a_q.push_back(ea(1'b0, 1'b0, 16'h0E02));
        exp_a_q.push_back(ea(1'b1, 1'b0, 16'h0E03));
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", a_dout.valid, 1);
            chk("t4_hold_data", a_dout.data, ea(1'b0, 1'b0, 16'h0E01));
            chk("t4_din0_ready", a_din0.ready, 0);
        end
        step();
        a_dout.ready = 1'b1;
        wait_drain("t4");
        chk("t4_count", n_out - n0, 3);
        chk("t4_back2back", out_cyc[n0 + 2] - out_cyc[n0], 2);

        // Test 6: reset in the middle of a din1 transaction; din0 wins the first tie afterwards.
        n0 = n_out;
        sa1_q.push_back(ia(1'b0, 16'h0F01));
        sa1_q.push_back(ia(1'b0, 16'h0F02));
        sa1_q.push_back(ia(1'b1, 16'h0F03));
        exp_a_q.push_back(ea(1'b0, 1'b1, 16'h0F01));
        exp_a_q.push_back(ea(1'b1, 1'b0, 16'h0601));
        exp_a_q.push_back(ea(1'b0, 1'b1, 16'h0F02));
        exp_a_q.push_back(ea(1'b1, 1'b1, 16'h0F03));
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_din1_ready", a_din1.ready, 0);
        step();
        sa0_q.push_back(ia(1'b1, 16'h0601));
        @(negedge clk);
        chk("t6_rst_dout_valid", a_dout.valid, 0);
        chk("t6_rst_state", a_state, 0);
        step();
        rst = 1'b0;
        wait_drain("t6");
        chk("t6_count", n_out - n0, 4);

        // Test 5: LVL=2, lock held across inner eot, released after outer eot.
        sb1_q.push_back(ib(2'b01, 16'h0501));
        sb1_q.push_back(ib(2'b01, 16'h0502));
        sb1_q.push_back(ib(2'b11, 16'h0503));
        exp_b_q.push_back(eb(2'b01, 1'b1, 16'h0501));
        exp_b_q.push_back(eb(2'b01, 1'b1, 16'h0502));
        exp_b_q.push_back(eb(2'b11, 1'b1, 16'h0503));
        exp_b_q.push_back(eb(2'b11, 1'b0, 16'h0701));
        step();
        sb0_q.push_back(ib(2'b11, 16'h0701));
        step();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t5_din0_blocked", b_din0.ready, 0);
            chk("t5_state_lock1", b_state, 2);
        end
        wait_drain("t5");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
